// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan reader: active-low glyph codes,
// segment bit positions and the capture FSM state encoding.
package seg_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // seg[6:0] codes, active-low, dp excluded
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        StWait,
        StSettle,
        StCaptured
    } seg_state_e;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph-to-nibble decoder. Hex letters A-F are legal only when
// SEG_DECODE_HEX_EN is defined; otherwise they decode as bad.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_value,
    output logic       o_blank,
    output logic       o_bad
);

    always_comb begin
        o_value = 4'h0;
        o_blank = 1'b0;
        o_bad   = 1'b0;
        case (i_seg)
            GLYPH_0:     o_value = 4'h0;
            GLYPH_1:     o_value = 4'h1;
            GLYPH_2:     o_value = 4'h2;
            GLYPH_3:     o_value = 4'h3;
            GLYPH_4:     o_value = 4'h4;
            GLYPH_5:     o_value = 4'h5;
            GLYPH_6:     o_value = 4'h6;
            GLYPH_7:     o_value = 4'h7;
            GLYPH_8:     o_value = 4'h8;
            GLYPH_9:     o_value = 4'h9;
`ifdef SEG_DECODE_HEX_EN
            GLYPH_A:     o_value = 4'hA;
            GLYPH_B:     o_value = 4'hB;
            GLYPH_C:     o_value = 4'hC;
            GLYPH_D:     o_value = 4'hD;
            GLYPH_E:     o_value = 4'hE;
            GLYPH_F:     o_value = 4'hF;
`endif
            GLYPH_BLANK: o_blank = 1'b1;
            default:     o_bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Receive side of a multiplexed 4-digit seven-segment display: synchronizes an/seg,
// captures each settled digit and emits complete frames. Option macro: SEG_DECODE_HEX_EN.
module seven_seg_scan_reader
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W          = 17
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_an,
    input  logic [7:0]  i_seg,
    output logic [15:0] o_digits,
    output logic [3:0]  o_dp_out,
    output logic [3:0]  o_blank,
    output logic [3:0]  o_bad,
    output logic        o_frame_valid,
    output logic        o_multi_err,
    output logic        o_scan_stall
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_MAX     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    logic [3:0]       r_an_s1, r_an_s2, r_an_prev;
    logic [7:0]       r_seg_s1, r_seg_s2, r_seg_prev;
    logic [CNT_W-1:0] r_stab, r_tmo;
    seg_state_e       r_state, w_state_next;
    logic             w_single, w_multi, w_changed, w_capture;
    logic [1:0]       w_idx;
    logic [3:0]       w_dec_val;
    logic             w_dec_blank, w_dec_bad;
    logic [15:0]      r_slot_val, r_digits;
    logic [3:0]       r_slot_dp, r_slot_blank, r_slot_bad;
    logic [3:0]       r_dp, r_blank, r_bad;
    logic [3:0]       r_seen, w_seen_next;
    logic             r_frame_valid, r_multi_err;

    seg_glyph_decode u_decode (
        .i_seg   (r_seg_s2[SEG_G:SEG_A]),
        .o_value (w_dec_val),
        .o_blank (w_dec_blank),
        .o_bad   (w_dec_bad)
    );

    always_comb begin
        w_single = 1'b1;
        w_idx    = 2'd0;
        case (r_an_s2)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_single = 1'b0;
        endcase
    end

    assign w_multi   = !w_single && (r_an_s2 != 4'hF);
    assign w_changed = {r_an_s2, r_seg_s2} != {r_an_prev, r_seg_prev};

    // Synchronizer and history flops reset to the idle pattern so a freshly
    // released reset never looks like several anodes driven low.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_an_s1    <= 4'hF;
            r_an_s2    <= 4'hF;
            r_an_prev  <= 4'hF;
            r_seg_s1   <= 8'hFF;
            r_seg_s2   <= 8'hFF;
            r_seg_prev <= 8'hFF;
            r_stab     <= '0;
        end else begin
            r_an_s1    <= i_an;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
            r_seg_s1   <= i_seg;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            if (w_changed) begin
                r_stab <= '0;
            end else if (r_stab != CNT_SAT) begin
                r_stab <= r_stab + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StWait;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StWait: begin
                if (w_single) w_state_next = StSettle;
            end
            StSettle: begin
                if (!w_single)      w_state_next = StWait;
                else if (w_capture) w_state_next = StCaptured;
            end
            StCaptured: begin
                if (!w_single)      w_state_next = StWait;
                else if (w_changed) w_state_next = StSettle;
            end
            default: w_state_next = StWait;
        endcase
    end

    always_comb begin
        w_capture = (r_state == StSettle) && w_single && !w_changed && (r_stab == SETTLE_LAST);
    end

    // A full mask retires the frame; a capture on that same edge starts the next one.
    always_comb begin
        w_seen_next = (r_seen == 4'hF) ? 4'h0 : r_seen;
        if (w_capture) w_seen_next[w_idx] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_slot_val    <= '0;
            r_slot_dp     <= '0;
            r_slot_blank  <= '0;
            r_slot_bad    <= '0;
            r_seen        <= '0;
            r_digits      <= '0;
            r_dp          <= '0;
            r_blank       <= '0;
            r_bad         <= '0;
            r_frame_valid <= 1'b0;
            r_multi_err   <= 1'b0;
            r_tmo         <= '0;
        end else begin
            if (w_capture) begin
                r_slot_val[{w_idx, 2'b00} +: 4] <= w_dec_val;
                r_slot_dp[w_idx]                <= ~r_seg_s2[SEG_DP];
                r_slot_blank[w_idx]             <= w_dec_blank;
                r_slot_bad[w_idx]               <= w_dec_bad;
            end
            r_frame_valid <= (r_seen == 4'hF);
            if (r_seen == 4'hF) begin
                r_digits <= r_slot_val;
                r_dp     <= r_slot_dp;
                r_blank  <= r_slot_blank;
                r_bad    <= r_slot_bad;
            end
            r_seen <= w_seen_next;
            if (w_multi) r_multi_err <= 1'b1;
            if (w_capture) begin
                r_tmo <= '0;
            end else if (r_tmo != TMO_MAX) begin
                r_tmo <= r_tmo + CNT_ONE;
            end
        end
    end

    assign o_digits      = r_digits;
    assign o_dp_out      = r_dp;
    assign o_blank       = r_blank;
    assign o_bad         = r_bad;
    assign o_frame_valid = r_frame_valid;
    assign o_multi_err   = r_multi_err;
    assign o_scan_stall  = (r_tmo == TMO_MAX);

endmodule

// File: doc/seven_seg_scan_reader.md
Name: seven_seg_scan_reader

Overview:
Receive side of the multiplexed 4-digit seven-segment interface driven by top (an/seg).
- Samples the scanned anode/segment lines and tracks the anode rotation.
- Decodes each digit's glyph back to a 4-bit value and assembles complete 4-digit frames.
- Used for board loopback and self-checking benches of the stopwatch display path.

Parameters:
SETTLE_CYCLES, 4, consecutive cycles an/seg must be stable before a digit is captured (min 1)
TIMEOUT_CYCLES, 65536, cycles without any capture before scan_stall asserts
CNT_W, 17, width of stability/timeout counters (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low
an  input  4  anode selects, active-low, an[0] = rightmost digit
seg  input  8  segments, active-low, seg[0]=a..seg[6]=g, seg[7]=dp
digits  output  16  last complete frame, digit i at [4i+3:4i]
dp_out  output  4  decimal point per digit (1 = lit)
blank  output  4  digit had all segments off
bad  output  4  digit pattern not a legal glyph
frame_valid  output  1  one-cycle pulse when digits/dp_out/blank/bad update
multi_err  output  1  sticky; more than one anode seen low
scan_stall  output  1  no capture for TIMEOUT_CYCLES

Behaviour:
- Reset (rst=0 at clk edge):
  - Clears all outputs to 0, the slot registers, the seen mask, the counters, and the synchronizer flops.
  - FSM goes to WAIT.
  - Reset mid-frame discards any partial frame.
- Input synchronizer: 2-flop synchronizer on an and seg. All logic uses the synchronized copies.
- Anode classification:
  - Exactly one bit low: digit index k.
  - All high: idle.
  - Two or more low: sets multi_err (sticky until reset) and is treated as idle.
- Stability counter:
  - Clears whenever synchronized {an,seg} differs from the previous cycle.
  - Otherwise increments, saturating.
- FSM:
  - WAIT → SETTLE when a valid single anode appears.
  - SETTLE → WAIT if the anode goes idle or invalid.
  - SETTLE → CAPTURED on the cycle the counter reaches SETTLE_CYCLES-1:
    - Write slot k with decoded value, dp, blank and bad.
    - Set seen[k].
    - Clear the timeout counter.
  - CAPTURED → SETTLE on any change of {an,seg} to a valid single anode; → WAIT on idle.
  - Exactly one capture per dwell.
- Latency: a capture occurs SETTLE_CYCLES+2 cycles after the first stable input cycle.
- Recapture of a digit already in seen overwrites its slot. The seen bit stays set.
- Frame completion:
  - On the cycle seen becomes 4'b1111, the next edge copies the slots to digits/dp_out/blank/bad.
  - At that same edge frame_valid=1 for one cycle and seen clears.
  - A capture on that same cycle sets seen[k] for the new frame.
- Glyph decode:
  - Standard hex glyphs, active-low: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E.
  - These codes are seg[6:0] with bit 7 as dp, shown with dp off.
  - Decode ignores seg[7].
  - seg[6:0]=7'h7F: value 0, blank=1.
  - Any other pattern: value 0, bad=1.
- Timeout:
  - Counts while no capture occurs.
  - At TIMEOUT_CYCLES, scan_stall=1 and the counter saturates.
  - scan_stall clears on the next capture.

Optional Feature:
SEG_DECODE_HEX_EN
- Defined: glyphs A–F decode to 4'hA–4'hF.
- Undefined: only 0–9 are legal. Patterns 88/83/C6/A1/86/8E yield value 0 with bad=1. The logic for A–F is not synthesized.

Decomposition:
- Package seg_pkg holds:
  - glyph constants GLYPH_0..GLYPH_F and GLYPH_BLANK (7-bit, active-low);
  - FSM state encoding WAIT/SETTLE/CAPTURED;
  - segment bit-index constants.
- One sub-module seg_glyph_decode: purely combinational, seg[6:0] → {value[3:0], blank, bad}, honouring SEG_DECODE_HEX_EN. The FSM, counters and frame assembly stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with an=4'b1110, seg=8'hC0 → all outputs 0, no capture while rst=0.
- Clean scan: drive an=1110/1101/1011/0111 with seg=F9/A4/B0/99 for 10 cycles each (SETTLE_CYCLES=4) → frame_valid pulses once, digits=16'h4321, blank=0, bad=0.
- Glitch rejection: on digit 0 toggle seg between C0 and F9 every 2 cycles, then hold C0 for 8 cycles → slot 0 captures 0 only. Exactly one capture for the dwell.
- Multi-anode / blank / dp: an=4'b1100 for 10 cycles → multi_err=1, no capture. Scan with digit 2 seg=FF and digit 1 seg=40 → blank[2]=1, dp_out[1]=1, digits[7:4]=0.
- Hex option: scan seg=88 on all digits → with SEG_DECODE_HEX_EN digits=16'hAAAA, bad=0; without it digits=0, bad=4'hF.
- Stall: TIMEOUT_CYCLES=100, hold an=4'hF for 120 cycles → scan_stall rises exactly 100 cycles after the last capture. It clears on the next capture. Asserting rst mid-frame → no frame_valid until 4 fresh captures.
